// File: rtl/div64.sv
// div64: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
// and their W variants. One quotient bit per cycle. Divide-by-zero and
// signed overflow bypass the iteration and finish one cycle after acceptance.
module div64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             is_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    // Working registers: dvd holds the dividend magnitude and collects
    // quotient bits from the LSB as it shifts; rem is the partial remainder.
    logic [63:0] dvd, rem, dsr;
    logic [5:0]  cnt;
    logic        word_q, qneg, rneg, special;

    logic signed [63:0] a_ext, b_ext;
    logic [63:0]        a_mag, b_mag;
    logic               a_neg, b_neg, div_zero, overflow;

    logic [64:0] shifted;
    logic [64:0] trial;
    logic        q_bit;
    logic [63:0] rem_nxt, quo_nxt;

    logic accept;

    function automatic logic [63:0] negate(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Sign fixup, then word results are sign-extended from bit 31 even for
    // the unsigned W ops.
    function automatic logic [63:0] fixup(input logic [63:0] x, input logic neg,
                                          input logic word);
        logic [63:0] y;
        y = neg ? negate(x) : x;
        return word ? sext32(y[31:0]) : y;
    endfunction

    // Operand preparation: width/sign extension, magnitudes, special cases.
    always_comb begin
        if (is_word) begin
            a_ext = is_signed ? sext32(dividend[31:0]) : {32'd0, dividend[31:0]};
            b_ext = is_signed ? sext32(divisor[31:0])  : {32'd0, divisor[31:0]};
        end else begin
            a_ext = dividend;
            b_ext = divisor;
        end
        a_neg    = is_signed & a_ext[63];
        b_neg    = is_signed & b_ext[63];
        a_mag    = a_neg ? negate(a_ext) : a_ext;
        b_mag    = b_neg ? negate(b_ext) : b_ext;
        div_zero = (b_ext == '0);
        overflow = is_signed && (b_ext == '1) &&
                   (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    end

    // One restoring step: shift in next dividend bit, trial subtract.
    // shifted < 2*dsr, so the 65-bit difference never wraps and bit 64 is its sign.
    always_comb begin
        shifted = {rem, dvd[63]};
        trial   = shifted - {1'b0, dsr};
        q_bit   = ~trial[64];
        rem_nxt = q_bit ? trial[63:0] : shifted[63:0];
        quo_nxt = {dvd[62:0], q_bit};
    end

    assign accept = (state == IDLE) && in_valid && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (special || cnt == 6'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: load on accept (special results are parked in dvd/rem), iterate in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= is_word;
            qneg    <= a_neg ^ b_neg;
            rneg    <= a_neg;
            special <= div_zero | overflow;
            dsr     <= b_mag;
            cnt     <= is_word ? 6'd31 : 6'd63;
            if (div_zero) begin
                dvd <= '1;
                rem <= is_word ? sext32(dividend[31:0]) : dividend;
            end else if (overflow) begin
                dvd <= a_ext;
                rem <= '0;
            end else begin
                dvd <= is_word ? {a_mag[31:0], 32'd0} : a_mag;
                rem <= '0;
            end
        end else if (state == CALC && !special) begin
            dvd <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt - 6'd1;
        end
    end

    // Result registers, written only on the transition into DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (state == CALC && !flush) begin
            if (special) begin
                quotient  <= dvd;
                remainder <= rem;
            end else if (cnt == 6'd0) begin
                quotient  <= fixup(quo_nxt, qneg, word_q);
                remainder <= fixup(rem_nxt, rneg, word_q);
            end
        end
    end

endmodule

// File: tb/tb_div64.sv
// tb_div64: scoreboard bench for div64. The driver pushes expected results
// when it issues an operation; a monitor pops and compares on each result
// handshake.
module tb_div64;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [63:0] dividend, divisor;
    logic        is_signed, is_word;
    logic        out_valid, out_ready;
    logic [63:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] mon_e;

    div64 #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .is_word   (is_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on every completed result handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("quotient", quotient, mon_e[127:64]);
                    chk("remainder", remainder, mon_e[63:0]);
                end
            end
        end
    end

    task automatic start(input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic w);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        is_word   = w;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic [63:0] eq,
                       input logic [63:0] er, input int lat, input bit hold);
        int n;
        int m;
        exp_q.push_back({eq, er});
        if (hold) out_ready = 1'b0;
        start(a, b, s, w);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(lat));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
                chk({name, "_hold_quotient"}, quotient, eq);
                chk({name, "_hold_remainder"}, remainder, er);
                chk({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        m = 0;
        while (out_valid && m < 10) begin
            @(posedge clk);
            #1;
            m++;
        end
        if (out_valid) chk({name, "_release"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        is_word   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        rst_n = 1'b1;

        run("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 64, 1'b0);
        run("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run("div_m7_m2", 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
            64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run("divu_max_16", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0,
            64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 64, 1'b0);
        run("div0_signed", 64'h1234, 64'd0, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 1'b0);
        run("div0_unsigned", 64'h1234, 64'd0, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 1'b0);
        run("ovf64", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
            64'h8000_0000_0000_0000, 64'd0, 1, 1'b0);
        run("ovf_word", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
            64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b0);
        run("divw_m7_2", 64'h1234_5678_FFFF_FFF9, 64'd2, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b0);
        run("divuw_hold", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32, 1'b1);

        // Flush in the middle of an iteration: nothing is pushed for this op.
        start(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);

        // A request raised together with flush must not be taken.
        @(negedge clk);
        dividend = 64'd50;
        divisor  = 64'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_blocks_accept", 64'(in_ready), 64'd1);

        run("divu_9_3_after_flush", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 64, 1'b0);

        // Reset in the middle of an iteration.
        start(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_quotient", quotient, 64'd0);
        chk("midreset_remainder", remainder, 64'd0);
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
